pin_driver: RTL and testbench

PIN_DRIVER -- requirements
Module: pin_driver

---
 rtl/pin_pkg.sv | 6 +
 rtl/pin_driver_fifo.sv | 34 +++
 rtl/pin_driver.sv | 81 ++++++++
 tb/tb_pin_driver.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pin_pkg.sv
// pin_pkg: shared FSM state type and default constants for the pin driver
package pin_pkg;
    typedef enum logic {IDLE, HOLD} state_t;
    localparam int PIN_HOLD_TICKS_DEF = 2;
    localparam int PIN_FIFO_DEPTH_DEF = 4;
endpackage

// File: rtl/pin_driver_fifo.sv
// pin_driver_fifo: 1-bit request queue with registered pointers and sync active-low reset
module pin_driver_fifo import pin_pkg::*; #(
    parameter int DEPTH = PIN_FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DEPTH-1:0] mem;
    logic [AW:0] wr_ptr, rd_ptr;
    // pointer update; full gates push even when a pop happens in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    // storage needs no reset; only pointers define validity
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end
    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/pin_driver.sv
// pin_driver: queued pin level driver holding each level for HOLD_TICKS ena strobes;
// define PIN_DRIVER_OPENDRAIN_EN for open-drain pad signalling (push-pull otherwise)
module pin_driver import pin_pkg::*; #(
    parameter int HOLD_TICKS = PIN_HOLD_TICKS_DEF,
    parameter int FIFO_DEPTH = PIN_FIFO_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ena,
    input  logic din,
    input  logic din_valid,
    output logic din_ready,
    output logic pad_o,
    output logic pad_oe,
    output logic level,
    output logic busy
);
    localparam int CW = $clog2(HOLD_TICKS + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic level_nx, rdy_q, pop, fifo_dout, full, empty;

    pin_driver_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(din_valid && din_ready),
        .din(din),
        .pop(pop),
        .dout(fifo_dout),
        .full(full),
        .empty(empty)
    );

    assign pop       = !empty && (state == IDLE || cnt == '0);
    assign din_ready = rdy_q && !full;
    assign busy      = (state == HOLD) || !empty;

    // state, hold counter and driven level registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b1;
            rdy_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
            rdy_q <= 1'b1;
        end
    end

    // a pop reloads the hold (ena in that cycle is ignored); otherwise count down ena strobes
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        if (pop) begin
            state_nx = HOLD;
            cnt_nx   = CW'(HOLD_TICKS);
            level_nx = fifo_dout;
        end else if (state == HOLD) begin
            if (cnt == '0) state_nx = IDLE;
            else if (ena) cnt_nx = cnt - 1'b1;
        end
    end

`ifdef PIN_DRIVER_OPENDRAIN_EN
    assign pad_o  = 1'b0;
    assign pad_oe = ~level;
`else
    logic oe_q;
    // push-pull pad stays tri-stated until the first requested level is driven
    always_ff @(posedge clk) begin
        if (!reset_n) oe_q <= 1'b0;
        else if (pop) oe_q <= 1'b1;
    end
    assign pad_o  = level;
    assign pad_oe = oe_q;
`endif
endmodule

// File: tb/tb_pin_driver.sv
// tb_pin_driver: directed table plus hand sequences for pin_driver (HOLD_TICKS=2, FIFO_DEPTH=4)
module tb_pin_driver;
    logic clk = 1'b0;
    logic reset_n = 1'b0, ena = 1'b0, din = 1'b0, din_valid = 1'b0;
    logic din_ready, pad_o, pad_oe, level, busy;
    int n_chk = 0, n_fail = 0;

    pin_driver #(.HOLD_TICKS(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .pad_o(pad_o), .pad_oe(pad_oe), .level(level), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst_n, en, d, vld;
        logic e_level, e_oe, e_busy, e_rdy;
    } vec_t;
    vec_t tbl[22];

    task automatic chk(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // pad expectations derived from level and the push-pull enable state
    task automatic chk_pad(input string name, input logic lvl, input logic pp_oe);
`ifdef PIN_DRIVER_OPENDRAIN_EN
        chk({name, ".pad_o"}, pad_o, 1'b0);
        chk({name, ".pad_oe"}, pad_oe, ~lvl);
`else
        chk({name, ".pad_o"}, pad_o, lvl);
        chk({name, ".pad_oe"}, pad_oe, pp_oe);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic prev;
        logic [3:0] seq;
        int changes, strobes, acc;
        logic [5:0] vals;
        logic ena_applied;
        tbl = '{
            '{0,1,0,0, 1,0,0,0}, '{0,1,0,0, 1,0,0,0}, '{1,1,0,0, 1,0,0,1}, '{1,1,0,0, 1,0,0,1},
            '{1,1,0,1, 1,0,1,1}, '{1,1,0,0, 0,1,1,1}, '{1,1,0,0, 0,1,1,1}, '{1,1,0,0, 0,1,1,1},
            '{1,1,0,0, 0,1,0,1}, '{1,1,0,0, 0,1,0,1}, '{1,0,1,1, 0,1,1,1}, '{1,0,0,0, 1,1,1,1},
            '{1,0,0,0, 1,1,1,1}, '{1,1,0,0, 1,1,1,1}, '{1,0,0,0, 1,1,1,1}, '{1,1,0,0, 1,1,1,1},
            '{1,0,0,0, 1,1,0,1}, '{1,1,1,1, 1,1,1,1}, '{1,1,0,0, 1,1,1,1}, '{1,1,0,0, 1,1,1,1},
            '{1,1,0,0, 1,1,1,1}, '{1,1,0,0, 1,1,0,1}
        };
        #2;
        for (int i = 0; i < 22; i++) begin
            reset_n = tbl[i].rst_n; ena = tbl[i].en; din = tbl[i].d; din_valid = tbl[i].vld;
            step();
            chk($sformatf("tbl[%0d].level", i), level, tbl[i].e_level);
            chk($sformatf("tbl[%0d].busy", i), busy, tbl[i].e_busy);
            chk($sformatf("tbl[%0d].din_ready", i), din_ready, tbl[i].e_rdy);
            chk_pad($sformatf("tbl[%0d]", i), tbl[i].e_level, tbl[i].e_oe);
        end
        din_valid = 0;

        // back-to-back 0,1,0,1 with ena every 4th clock: no gaps, each level >= 2 strobes
        prev = level; seq = '0; changes = 0; strobes = 0; acc = 0; vals = 6'b001010;
        for (int c = 0; c < 200 && !(changes == 4 && !busy); c++) begin
            ena = (c % 4 == 3);
            din_valid = (acc < 4);
            din = vals[acc];
            if (acc < 4) chk("seq.din_ready", din_ready, 1'b1);
            if (din_valid && din_ready) acc++;
            ena_applied = ena;
            step();
            if (level != prev) begin
                changes++;
                if (changes > 1) chk("seq.hold_len", strobes >= 2, 1'b1);
                strobes = 0;
                seq = {seq[2:0], level};
                prev = level;
            end else if (ena_applied) strobes++;
            if (changes >= 1 && changes < 4) chk("seq.no_gap_busy", busy, 1'b1);
        end
        din_valid = 0; ena = 0;
        chk("seq.done", changes == 4 && !busy, 1'b1);
        chk("seq.last_hold_len", strobes >= 2, 1'b1);
        chk("seq.order", seq == 4'b0101, 1'b1);

        // fill the FIFO with ena low: stall when 4 queued, release after first hold ends
        acc = 0; vals = 6'b101010;
        for (int c = 0; c < 10 && din_ready; c++) begin
            din_valid = 1; din = vals[acc];
            step();
            acc++;
        end
        chk("full.accepted5", acc == 5, 1'b1);
        chk("full.din_ready", din_ready, 1'b0);
        chk("full.level", level, 1'b0);
        din = vals[5];
        for (int c = 0; c < 3; c++) begin
            step();
            chk("full.stall", din_ready, 1'b0);
        end
        ena = 1; step(); step();
        chk("full.stall_cnt0", din_ready, 1'b0);
        ena = 0; step();
        chk("full.popped_level", level, 1'b1);
        chk("full.ready_again", din_ready, 1'b1);
        step();
        din_valid = 0;
        chk("full.refilled", din_ready, 1'b0);
        chk("full.busy", busy, 1'b1);

        // reset mid-HOLD with requests queued: nothing queued may reach the pad
        reset_n = 0; step();
        chk("rst.level", level, 1'b1);
        chk("rst.busy", busy, 1'b0);
        chk("rst.din_ready", din_ready, 1'b0);
        chk_pad("rst", 1'b1, 1'b0);
        reset_n = 1; ena = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("post_rst.level", level, 1'b1);
            chk("post_rst.busy", busy, 1'b0);
            chk_pad("post_rst", 1'b1, 1'b0);
        end
        chk("post_rst.din_ready", din_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
